// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one value per handshake.
// Feeds ready-made BCD digits to the multiplexed seven-segment driver.
module bin_to_bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int MAX_VAL = 9999
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    bin_in,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                out_valid,
  output logic                overflow,
  output logic                busy
);

  // state | meaning
  // IDLE  | waiting for a handshake, outputs hold last result
  // SHIFT | BIN_W add-3/shift cycles on {scratch, sat}
  // DONE  | publish scratch to bcd_out, pulse out_valid

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BIN_W-1:0]   sat;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pending;

  always_comb begin
    scratch_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      else
        scratch_adj[4*d +: 4] = scratch[4*d +: 4];
    end
  end

  assign busy = ~in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      bcd_out     <= '0;
      scratch     <= '0;
      sat         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sat         <= (bin_in > MAX_BIN) ? MAX_BIN : bin_in;
            ovf_pending <= (bin_in > MAX_BIN);
            scratch     <= '0;
            cnt         <= CNT_W'(BIN_W);
            in_ready    <= 1'b0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[BCD_W-2:0], sat[BIN_W-1]};
          sat     <= {sat[BIN_W-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= DONE;
        end
        DONE: begin
          bcd_out   <= scratch;
          overflow  <= ovf_pending;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, saturation, hold-valid throughput,
// reset abort and back-to-back ordering, all against hand-computed BCD values.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] bin_in;
  logic [15:0] bcd_out;
  logic        out_valid;
  logic        overflow;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] prev_bcd = 16'h0000;

  always #5 clk = ~clk;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .out_valid(out_valid),
    .overflow (overflow),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [13:0] v);
    int guard = 0;
    in_valid = 1'b1;
    bin_in   = v;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      check({tag, "_hold"}, {16'd0, bcd_out}, {16'd0, prev_bcd});
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd15);
    check({tag, "_bcd"}, {16'd0, bcd_out}, {16'd0, exp_bcd});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    prev_bcd = exp_bcd;
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int hs_cnt, pulse_cnt, hs_first, hs_second, nv;
    reset    = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ovf",   {31'd0, overflow}, 32'd0);
    check("rst_bcd",   {16'd0, bcd_out}, 32'd0);

    // 1: basic conversion and latency
    send(14'd9625);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_result("t1", 16'h9625, 1'b0);

    // 2: range ends
    send(14'd0);
    wait_result("t2a", 16'h0000, 1'b0);
    send(14'd9999);
    wait_result("t2b", 16'h9999, 1'b0);

    // 3: saturation, including the first and last out-of-range codes
    send(14'd12000);
    wait_result("t3a", 16'h9999, 1'b1);
    send(14'd9186);
    wait_result("t3b", 16'h9186, 1'b0);
    send(14'd10000);
    wait_result("t3c", 16'h9999, 1'b1);
    send(14'd16383);
    wait_result("t3d", 16'h9999, 1'b1);
    send(14'd1);
    wait_result("t3e", 16'h0001, 1'b0);

    // 4: in_valid held; window sized for exactly two handshakes
    hs_cnt = 0; pulse_cnt = 0; hs_first = -1; hs_second = -1;
    in_valid = 1'b1;
    bin_in   = 14'd9224;
    for (int c = 0; c < 52; c++) begin
      if (c == 32) in_valid = 1'b0;
      if (in_valid && in_ready) begin
        if (hs_cnt == 0) hs_first = c;
        else if (hs_cnt == 1) hs_second = c;
        hs_cnt++;
      end
      if (out_valid) begin
        pulse_cnt++;
        check("t4_bcd", {16'd0, bcd_out}, 32'h9224);
      end
      @(negedge clk);
    end
    check("t4_hs", hs_cnt, 32'd2);
    check("t4_gap", hs_second - hs_first, 32'd16);
    check("t4_pulses", pulse_cnt, 32'd2);
    prev_bcd = 16'h9224;

    // 5: reset mid-conversion, with in_valid asserted during reset
    send(14'd9756);
    repeat (4) @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    bin_in   = 14'd1234;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    check("t5_bcd",   {16'd0, bcd_out}, 32'd0);
    check("t5_ready", {31'd0, in_ready}, 32'd1);
    check("t5_busy",  {31'd0, busy}, 32'd0);
    check("t5_ovf",   {31'd0, overflow}, 32'd0);
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) nv++;
      @(negedge clk);
    end
    check("t5_no_pulse", nv, 32'd0);
    prev_bcd = 16'h0000;

    // 6: back-to-back ordering
    send(14'd9625);
    wait_result("t6a", 16'h9625, 1'b0);
    send(14'd9224);
    wait_result("t6b", 16'h9224, 1'b0);
    send(14'd9756);
    wait_result("t6c", 16'h9756, 1'b0);
    send(14'd9186);
    wait_result("t6d", 16'h9186, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
